// File: rtl/alu_pwr_seq.sv
// Power-sequencing controller for the gated ALU domain: drains, clamps, isolates
// and removes power in a fixed order, and reverses that order on power-up.
module alu_pwr_seq #(
  parameter int unsigned PWR_UP_CYC = 4,
  parameter int unsigned RST_CYC    = 2,
  parameter int unsigned ISO_CYC    = 2,
  parameter int unsigned PWR_DN_CYC = 3,
  parameter int unsigned DRAIN_MAX  = 8,
  parameter logic [15:0] CLAMP_RST  = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pwr_req,
  input  logic        alu_busy,
  input  logic [15:0] alu_result,
  input  logic        start_in,
  output logic        start_out,
  output logic        alu_pwr_en,
  output logic        iso_en,
  output logic        alu_rst_n,
  output logic [15:0] clamp_value,
  output logic        alu_ready,
  output logic [2:0]  pwr_state,
  output logic        drain_timeout
);

  localparam int unsigned CNT_W = 8;
  localparam int unsigned DAT_W = 16;

  typedef enum logic [2:0] {
    S_OFF     = 3'd0,
    S_PWR_UP  = 3'd1,
    S_RST_REL = 3'd2,
    S_ON      = 3'd4,
    S_DRAIN   = 3'd5,
    S_ISO_ON  = 3'd6,
    S_PWR_DN  = 3'd7
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DAT_W-1:0]   clamp_q, clamp_d;
  logic               pwr_en_q, pwr_en_d;
  logic               iso_q, iso_d;
  logic               rst_n_q, rst_n_d;
  logic               ready_q, ready_d;
  logic               timeout_q, timeout_d;

  // Next-state, dwell counter and clamp capture
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CNT_W'(1);
    clamp_d   = clamp_q;
    timeout_d = 1'b0;
    case (state_q)
      S_OFF:     if (pwr_req) state_d = S_PWR_UP;
      S_PWR_UP:  if (cnt_q == CNT_W'(PWR_UP_CYC - 1)) state_d = S_RST_REL;
      S_RST_REL: if (cnt_q == CNT_W'(RST_CYC - 1)) state_d = S_ON;
      S_ON:      if (!pwr_req) state_d = S_DRAIN;
      S_DRAIN: begin
        if (!alu_busy) begin
          state_d = S_ISO_ON;
          clamp_d = alu_result;
        end else if (cnt_q == CNT_W'(DRAIN_MAX - 1)) begin
          state_d   = S_ISO_ON;
          clamp_d   = alu_result;
          timeout_d = 1'b1;
        end
      end
      S_ISO_ON:  if (cnt_q == CNT_W'(ISO_CYC - 1)) state_d = S_PWR_DN;
      S_PWR_DN:  if (cnt_q == CNT_W'(PWR_DN_CYC - 1)) state_d = S_OFF;
      default:   state_d = S_OFF;
    endcase
    if (state_d != state_q) cnt_d = '0;
  end

  // Domain controls are decoded from the next state so they register with it
  always_comb begin
    pwr_en_d = 1'b0;
    iso_d    = 1'b1;
    rst_n_d  = 1'b0;
    ready_d  = 1'b0;
    case (state_d)
      S_PWR_UP:  pwr_en_d = 1'b1;
      S_RST_REL: begin
        pwr_en_d = 1'b1;
        rst_n_d  = 1'b1;
      end
      S_ON: begin
        pwr_en_d = 1'b1;
        iso_d    = 1'b0;
        rst_n_d  = 1'b1;
        ready_d  = 1'b1;
      end
      S_DRAIN: begin
        pwr_en_d = 1'b1;
        iso_d    = 1'b0;
        rst_n_d  = 1'b1;
      end
      S_ISO_ON: begin
        pwr_en_d = 1'b1;
        rst_n_d  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_OFF;
      cnt_q     <= '0;
      clamp_q   <= CLAMP_RST;
      pwr_en_q  <= 1'b0;
      iso_q     <= 1'b1;
      rst_n_q   <= 1'b0;
      ready_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      clamp_q   <= clamp_d;
      pwr_en_q  <= pwr_en_d;
      iso_q     <= iso_d;
      rst_n_q   <= rst_n_d;
      ready_q   <= ready_d;
      timeout_q <= timeout_d;
    end
  end

  assign pwr_state     = state_q;
  assign alu_pwr_en    = pwr_en_q;
  assign iso_en        = iso_q;
  assign alu_rst_n     = rst_n_q;
  assign alu_ready     = ready_q;
  assign clamp_value   = clamp_q;
  assign drain_timeout = timeout_q;
  assign start_out     = start_in & ready_q;

endmodule

// File: tb/tb_alu_pwr_seq.sv
// Scoreboard bench for alu_pwr_seq: expected state entries are queued by the
// stimulus and checked by a monitor on every pwr_state change.
module tb_alu_pwr_seq;

  logic        clk = 1'b0;
  logic        rst, pwr_req, alu_busy, start_in;
  logic [15:0] alu_result;
  logic        start_out, alu_pwr_en, iso_en, alu_rst_n, alu_ready, drain_timeout;
  logic [15:0] clamp_value;
  logic [2:0]  pwr_state;

  alu_pwr_seq dut (
    .clk(clk), .rst(rst), .pwr_req(pwr_req), .alu_busy(alu_busy),
    .alu_result(alu_result), .start_in(start_in), .start_out(start_out),
    .alu_pwr_en(alu_pwr_en), .iso_en(iso_en), .alu_rst_n(alu_rst_n),
    .clamp_value(clamp_value), .alu_ready(alu_ready), .pwr_state(pwr_state),
    .drain_timeout(drain_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  st;
    logic        pwr, iso, rstn, rdy, to;
    logic [15:0] clamp;
    int          dwell;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  logic exp_rdy = 1'b0;
  int   to_pulses = 0;
  int   to_cycles = 0;

  task automatic chk(input bit ok, input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic void push(input logic [2:0] st, input logic pwr, input logic iso,
                               input logic rstn, input logic rdy, input logic to,
                               input logic [15:0] clamp, input int dwell);
    exp_t e;
    e.st = st; e.pwr = pwr; e.iso = iso; e.rstn = rstn; e.rdy = rdy;
    e.to = to; e.clamp = clamp; e.dwell = dwell;
    q.push_back(e);
  endfunction

  // Power-up entries; dwell 0 means the previous state's length is not checked
  function automatic void push_up(input logic [15:0] clamp);
    push(3'd1, 1, 1, 0, 0, 0, clamp, 0);
    push(3'd2, 1, 1, 1, 0, 0, clamp, 4);
    push(3'd4, 1, 0, 1, 1, 0, clamp, 2);
  endfunction

  function automatic void push_down(input logic [15:0] old_c, input logic [15:0] new_c,
                                    input int drain_dw, input logic to);
    push(3'd5, 1, 0, 1, 0, 0, old_c, 0);
    push(3'd6, 1, 1, 1, 0, to, new_c, drain_dw);
    push(3'd7, 0, 1, 0, 0, 0, new_c, 2);
    push(3'd0, 0, 1, 0, 0, 0, new_c, 3);
  endfunction

  // Monitor: scoreboard on state changes, ordering invariants, start gating
  initial begin : monitor
    logic [2:0] last_st;
    int         dwell;
    logic       prev_pwr, prev_iso, prev_to;
    exp_t       e;
    last_st = 3'd0; dwell = 0; prev_pwr = 1'b0; prev_iso = 1'b1; prev_to = 1'b0;
    forever begin
      @(negedge clk);
      chk(!(alu_rst_n && !alu_pwr_en), "inv_rstn_without_pwr", 32'(alu_rst_n), 32'(0));
      if (prev_pwr && !alu_pwr_en) chk(iso_en, "inv_iso_at_pwr_off", 32'(iso_en), 32'(1));
      if (prev_iso && !iso_en) chk(prev_pwr, "inv_pwr_before_unclamp", 32'(prev_pwr), 32'(1));
      if (pwr_state != last_st) begin
        if (q.size() == 0) begin
          chk(1'b0, "unexpected_state_change", 32'(pwr_state), 32'(last_st));
        end else begin
          e = q.pop_front();
          chk(pwr_state == e.st, "state", 32'(pwr_state), 32'(e.st));
          chk(alu_pwr_en == e.pwr, "alu_pwr_en", 32'(alu_pwr_en), 32'(e.pwr));
          chk(iso_en == e.iso, "iso_en", 32'(iso_en), 32'(e.iso));
          chk(alu_rst_n == e.rstn, "alu_rst_n", 32'(alu_rst_n), 32'(e.rstn));
          chk(alu_ready == e.rdy, "alu_ready", 32'(alu_ready), 32'(e.rdy));
          chk(drain_timeout == e.to, "drain_timeout", 32'(drain_timeout), 32'(e.to));
          chk(clamp_value == e.clamp, "clamp_value", 32'(clamp_value), 32'(e.clamp));
          if (e.dwell > 0) chk(dwell == e.dwell, "dwell", 32'(dwell), 32'(e.dwell));
          exp_rdy = e.rdy;
        end
        last_st = pwr_state;
        dwell = 1;
      end else begin
        dwell++;
      end
      if (start_in) chk(start_out == exp_rdy, "start_gate", 32'(start_out), 32'(exp_rdy));
      if (drain_timeout) to_cycles++;
      if (drain_timeout && !prev_to) to_pulses++;
      prev_pwr = alu_pwr_en; prev_iso = iso_en; prev_to = drain_timeout;
    end
  end

  task automatic wait_state(input logic [2:0] s, input int budget);
    int n;
    n = 0;
    while (pwr_state != s && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(pwr_state == s, "wait_state", 32'(pwr_state), 32'(s));
  endtask

  initial begin : stimulus
    int p0, c0;
    rst = 1'b1; pwr_req = 1'b0; alu_busy = 1'b0; alu_result = 16'h0; start_in = 1'b1;
    repeat (2) @(negedge clk);
    chk(pwr_state == 3'd0, "rst_state", 32'(pwr_state), 32'(0));
    chk(alu_pwr_en == 1'b0 && iso_en == 1'b1 && alu_rst_n == 1'b0, "rst_ctrl",
        32'({alu_pwr_en, iso_en, alu_rst_n}), 32'(3'b010));
    chk(alu_ready == 1'b0 && drain_timeout == 1'b0, "rst_ready_to",
        32'({alu_ready, drain_timeout}), 32'(0));
    chk(clamp_value == 16'h0000, "rst_clamp", 32'(clamp_value), 32'(0));
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Power-up with default timing
    push_up(16'h0000);
    pwr_req = 1'b1;
    wait_state(3'd4, 30);

    // Clean power-down, busy already low
    p0 = to_pulses;
    alu_result = 16'hBEEF;
    push_down(16'h0000, 16'hBEEF, 1, 1'b0);
    pwr_req = 1'b0;
    wait_state(3'd0, 40);
    chk(to_pulses == p0, "clean_no_timeout", 32'(to_pulses - p0), 32'(0));

    // Drain wait: busy for 5 DRAIN cycles, result changes as busy drops
    push_up(16'hBEEF);
    pwr_req = 1'b1;
    wait_state(3'd4, 30);
    p0 = to_pulses;
    push_down(16'hBEEF, 16'h1234, 5, 1'b0);
    alu_result = 16'h5555;
    alu_busy = 1'b1;
    pwr_req = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    alu_busy = 1'b0;
    alu_result = 16'h1234;
    wait_state(3'd0, 40);
    chk(to_pulses == p0, "wait_no_timeout", 32'(to_pulses - p0), 32'(0));

    // Forced drain with busy stuck high
    push_up(16'h1234);
    pwr_req = 1'b1;
    wait_state(3'd4, 30);
    p0 = to_pulses; c0 = to_cycles;
    push_down(16'h1234, 16'hA5A5, 8, 1'b1);
    alu_result = 16'hA5A5;
    alu_busy = 1'b1;
    pwr_req = 1'b0;
    wait_state(3'd0, 60);
    alu_busy = 1'b0;
    chk(to_pulses - p0 == 1, "forced_timeout_pulses", 32'(to_pulses - p0), 32'(1));
    chk(to_cycles - c0 == 1, "forced_timeout_width", 32'(to_cycles - c0), 32'(1));

    // Request glitch during PWR_UP is ignored; domain stays on
    push_up(16'hA5A5);
    pwr_req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    pwr_req = 1'b0;
    @(negedge clk);
    pwr_req = 1'b1;
    wait_state(3'd4, 30);
    repeat (4) @(negedge clk);
    chk(pwr_state == 3'd4, "glitch_stays_on", 32'(pwr_state), 32'(4));

    // Async reset mid ISO_ON
    alu_result = 16'h0F0F;
    push(3'd5, 1, 0, 1, 0, 0, 16'hA5A5, 0);
    push(3'd6, 1, 1, 1, 0, 0, 16'h0F0F, 1);
    pwr_req = 1'b0;
    wait_state(3'd6, 20);
    push(3'd0, 0, 1, 0, 0, 0, 16'h0000, 0);
    #2;
    rst = 1'b1;
    #1;
    chk(pwr_state == 3'd0, "async_state", 32'(pwr_state), 32'(0));
    chk(alu_pwr_en == 1'b0 && iso_en == 1'b1 && alu_rst_n == 1'b0, "async_ctrl",
        32'({alu_pwr_en, iso_en, alu_rst_n}), 32'(3'b010));
    chk(clamp_value == 16'h0000, "async_clamp", 32'(clamp_value), 32'(0));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Request dropped during RST_REL: one ON cycle, then power-down
    push_up(16'h0000);
    push_down(16'h0000, 16'h7777, 1, 1'b0);
    pwr_req = 1'b1;
    wait_state(3'd2, 20);
    pwr_req = 1'b0;
    alu_result = 16'h7777;
    wait_state(3'd0, 40);
    repeat (3) @(negedge clk);

    chk(q.size() == 0, "scoreboard_drained", 32'(q.size()), 32'(0));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
